pio_rw_mem_wide: RTL and testbench

- PIO-accessible single-port-pair RAM, successor to the narrow PIO memory.
- Entries may be wider than one PIO dword: each entry is split across WPE = ceil(WIDTH/32) PIO dwords.
- Wide PIO accesses are coherent: writes go through a staging register, reads through a snapshot register.
- Optional post-reset clear engine. Sits between PIO register decode and a datapath client that owns the app read/write ports.

---
 rtl/pio_rw_mem_wide_if.sv | 38 +++
 rtl/pio_rw_mem_wide.sv | 206 ++++++++++++++++++++
 tb/tb_pio_rw_mem_wide.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_rw_mem_wide_if.sv
// Bus bundle between a PIO register decoder / datapath client (master) and
// the wide PIO memory (slave).
//   PIO side : reg_addr, reg_din, reg_rd, reg_wr, reg_ms -> memory
//              mem_ack, mem_rdata                        <- memory
//   App side : app_mem_rd/raddr, app_mem_wr/waddr/wdata   -> memory
//              app_mem_ack, app_mem_rdata                <- memory
interface pio_rw_mem_wide_if #(
  parameter int WIDTH       = 72,
  parameter int DEPTH_NBITS = 10
);
  logic [31:0]            reg_addr;
  logic [31:0]            reg_din;
  logic                   reg_rd;
  logic                   reg_wr;
  logic                   reg_ms;
  logic                   mem_ack;
  logic [31:0]            mem_rdata;

  logic                   app_mem_rd;
  logic [DEPTH_NBITS-1:0] app_mem_raddr;
  logic                   app_mem_wr;
  logic [DEPTH_NBITS-1:0] app_mem_waddr;
  logic [WIDTH-1:0]       app_mem_wdata;
  logic                   app_mem_ack;
  logic [WIDTH-1:0]       app_mem_rdata;

  modport master (
    output reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
    output app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata,
    input  mem_ack, mem_rdata, app_mem_ack, app_mem_rdata
  );

  modport slave (
    input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
    input  app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata,
    output mem_ack, mem_rdata, app_mem_ack, app_mem_rdata
  );
endinterface

// File: rtl/pio_rw_mem_wide.sv
// PIO-accessible RAM whose entries may be wider than one 32-bit PIO dword.
// Each entry occupies WPE = ceil(WIDTH/32) dwords of a 2^WORD_NBITS stride.
// PIO writes collect lower dwords in a staging register and commit the whole
// entry on the last dword; PIO reads of dword 0 snapshot the full entry so the
// remaining dwords are returned coherently from the snapshot.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clk_div       PIO clock-enable; mem_ack only updates when high
//   bus           slave side of pio_rw_mem_wide_if (PIO + app ports)
//   init_done     clear engine finished; accesses are serviced only when high
module pio_rw_mem_wide #(
  parameter int               WIDTH       = 72,
  parameter int               DEPTH_NBITS = 10,
  parameter int               WORD_NBITS  = 2,
  parameter bit               REG_WR_EN   = 1'b1,
  parameter bit               INIT_EN     = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  pio_rw_mem_wide_if.slave   bus,
  output logic               init_done
);
  localparam int WPE   = (WIDTH + 31) / 32;
  localparam int PADW  = WPE * 32;
  localparam int DEPTH = 1 << DEPTH_NBITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- init engine ----------------
  logic [1:0]             state_reg, state_next;
  logic [DEPTH_NBITS-1:0] init_addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = INIT_EN ? ST_INIT : ST_DONE;
      ST_INIT: if (init_addr_reg == DEPTH_NBITS'(DEPTH - 1)) state_next = ST_DONE;
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      init_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_INIT) init_addr_reg <= init_addr_reg + 1'b1;
    end
  end

  assign init_done = (state_reg == ST_DONE);

  // ---------------- registers ----------------
  logic                   pend_vld_reg, pend_wr_reg, rd_wait_reg;
  logic [DEPTH_NBITS-1:0] pend_entry_reg;
  logic [WORD_NBITS-1:0]  pend_w_reg;
  logic [31:0]            pend_din_reg;
  logic [31:0]            stage_reg [WPE];
  logic [31:0]            snap_reg  [WPE];
  logic                   n_ack_reg, mem_ack_reg, app_ack_reg;
  logic [31:0]            mem_rdata_reg;
  logic                   app_wr_d1_reg;
  logic [DEPTH_NBITS-1:0] app_waddr_d1_reg;
  logic [WIDTH-1:0]       app_wdata_d1_reg;

  // ---------------- PIO decode of the pending request ----------------
  logic pio_go, wr_go, rd_go, w_valid, w_last, w_zero;
  logic stage_en, commit_req, commit_fire, rd_issue, done_now, pio_complete;

  assign w_valid = 32'(pend_w_reg) < WPE;
  assign w_last  = 32'(pend_w_reg) == WPE - 1;
  assign w_zero  = (pend_w_reg == '0);

  assign pio_go     = init_done & pend_vld_reg;
  assign wr_go      = pio_go & pend_wr_reg;
  assign rd_go      = pio_go & ~pend_wr_reg;
  assign stage_en   = wr_go & REG_WR_EN & w_valid & ~w_last;
  assign commit_req = wr_go & REG_WR_EN & w_last;
  // The d1 app write owns the write port this cycle; the commit waits a cycle
  // so on a same-entry collision the PIO data is the one that survives.
  assign commit_fire = commit_req & ~app_wr_d1_reg;
  // App read owns the read port; a dword-0 PIO read waits for it to drop.
  assign rd_issue     = rd_go & w_zero & ~bus.app_mem_rd;
  assign done_now     = (wr_go & ~(commit_req & app_wr_d1_reg)) | (rd_go & ~w_zero);
  assign pio_complete = done_now | rd_wait_reg;

  // Full entry image for a commit: staged dwords plus the incoming top dword.
  logic [PADW-1:0] commit_pad;
  generate
    for (genvar gi = 0; gi < WPE; gi++) begin : g_commit
      if (gi == WPE - 1) begin : g_top
        assign commit_pad[gi*32 +: 32] = pend_din_reg;
      end else begin : g_low
        assign commit_pad[gi*32 +: 32] = stage_reg[gi];
      end
    end
  endgenerate

  // ---------------- RAM ----------------
  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   ram_we;
  logic [DEPTH_NBITS-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]       ram_wdata, ram_q;
  logic [PADW-1:0]        ram_q_pad;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = pend_entry_reg;
    ram_wdata = commit_pad[WIDTH-1:0];
    if (state_reg == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_addr_reg;
      ram_wdata = INIT_VAL;
    end else if (app_wr_d1_reg) begin
      ram_we    = 1'b1;
      ram_waddr = app_waddr_d1_reg;
      ram_wdata = app_wdata_d1_reg;
    end else if (commit_fire) begin
      ram_we    = 1'b1;
    end
  end

  assign ram_raddr = (init_done & bus.app_mem_rd) ? bus.app_mem_raddr : pend_entry_reg;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  // Zero-padded so dwords above WIDTH read back as 0.
  assign ram_q_pad = PADW'(ram_q);

  logic [31:0] snap_sel;
  always_comb begin
    snap_sel = '0;
    for (int i = 0; i < WPE; i++)
      if (pend_w_reg == WORD_NBITS'(i)) snap_sel = snap_reg[i];
  end

  // ---------------- control / datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_reg     <= 1'b0;
      pend_wr_reg      <= 1'b0;
      pend_entry_reg   <= '0;
      pend_w_reg       <= '0;
      pend_din_reg     <= '0;
      rd_wait_reg      <= 1'b0;
      n_ack_reg        <= 1'b0;
      mem_ack_reg      <= 1'b0;
      mem_rdata_reg    <= '0;
      app_ack_reg      <= 1'b0;
      app_wr_d1_reg    <= 1'b0;
      app_waddr_d1_reg <= '0;
      app_wdata_d1_reg <= '0;
      for (int i = 0; i < WPE; i++) begin
        stage_reg[i] <= '0;
        snap_reg[i]  <= '0;
      end
    end else begin
      // Strobes are latched in any state (including INIT) and held until served.
      if (pend_vld_reg) begin
        if (done_now | rd_issue) pend_vld_reg <= 1'b0;
      end else if (!rd_wait_reg && bus.reg_ms && (bus.reg_rd || bus.reg_wr)) begin
        pend_vld_reg   <= 1'b1;
        pend_wr_reg    <= bus.reg_wr;
        pend_entry_reg <= bus.reg_addr[DEPTH_NBITS+WORD_NBITS+1:WORD_NBITS+2];
        pend_w_reg     <= bus.reg_addr[WORD_NBITS+1:2];
        pend_din_reg   <= bus.reg_din;
      end

      rd_wait_reg <= rd_issue;

      for (int i = 0; i < WPE; i++) begin
        if (stage_en && pend_w_reg == WORD_NBITS'(i)) stage_reg[i] <= pend_din_reg;
        if (rd_wait_reg) snap_reg[i] <= ram_q_pad[i*32 +: 32];
      end

      if (rd_wait_reg)           mem_rdata_reg <= ram_q_pad[31:0];
      else if (rd_go && !w_zero) mem_rdata_reg <= snap_sel;

      if (pio_complete) n_ack_reg <= 1'b1;
      else if (clk_div) n_ack_reg <= 1'b0;
      if (clk_div) mem_ack_reg <= n_ack_reg;

      app_ack_reg      <= init_done & bus.app_mem_rd;
      app_wr_d1_reg    <= init_done & bus.app_mem_wr;
      app_waddr_d1_reg <= bus.app_mem_waddr;
      app_wdata_d1_reg <= bus.app_mem_wdata;
    end
  end

  assign bus.mem_ack       = mem_ack_reg;
  assign bus.mem_rdata     = mem_rdata_reg;
  assign bus.app_mem_ack   = app_ack_reg;
  assign bus.app_mem_rdata = ram_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.reg_addr[1:0],
                         bus.reg_addr[31:DEPTH_NBITS+WORD_NBITS+2], commit_pad};
endmodule

// File: tb/tb_pio_rw_mem_wide.sv
module tb_pio_rw_mem_wide;
  localparam int W  = 72;
  localparam int DN = 4;

  logic clk = 1'b0, rst = 1'b1, clk_div = 1'b0;
  always #5 clk = ~clk;

  logic          t_ms = 0, t_rd = 0, t_wr = 0, t_app_rd = 0, t_app_wr = 0, use_ro = 0;
  logic [31:0]   t_addr = 0, t_din = 0;
  logic [DN-1:0] t_app_raddr = 0, t_app_waddr = 0;
  logic [W-1:0]  t_app_wdata = 0;
  logic          init_done, init_done_ro;

  pio_rw_mem_wide_if #(.WIDTH(W), .DEPTH_NBITS(DN)) bus ();
  pio_rw_mem_wide_if #(.WIDTH(W), .DEPTH_NBITS(DN)) bus_ro ();

  assign bus.reg_addr         = t_addr;
  assign bus.reg_din          = t_din;
  assign bus.reg_rd           = t_rd;
  assign bus.reg_wr           = t_wr;
  assign bus.reg_ms           = t_ms & ~use_ro;
  assign bus.app_mem_rd       = t_app_rd & ~use_ro;
  assign bus.app_mem_raddr    = t_app_raddr;
  assign bus.app_mem_wr       = t_app_wr & ~use_ro;
  assign bus.app_mem_waddr    = t_app_waddr;
  assign bus.app_mem_wdata    = t_app_wdata;
  assign bus_ro.reg_addr      = t_addr;
  assign bus_ro.reg_din       = t_din;
  assign bus_ro.reg_rd        = t_rd;
  assign bus_ro.reg_wr        = t_wr;
  assign bus_ro.reg_ms        = t_ms & use_ro;
  assign bus_ro.app_mem_rd    = t_app_rd & use_ro;
  assign bus_ro.app_mem_raddr = t_app_raddr;
  assign bus_ro.app_mem_wr    = t_app_wr & use_ro;
  assign bus_ro.app_mem_waddr = t_app_waddr;
  assign bus_ro.app_mem_wdata = t_app_wdata;

  logic          o_mem_ack, o_app_ack;
  logic [31:0]   o_mem_rdata;
  logic [W-1:0]  o_app_rdata;
  assign o_mem_ack   = use_ro ? bus_ro.mem_ack       : bus.mem_ack;
  assign o_mem_rdata = use_ro ? bus_ro.mem_rdata     : bus.mem_rdata;
  assign o_app_ack   = use_ro ? bus_ro.app_mem_ack   : bus.app_mem_ack;
  assign o_app_rdata = use_ro ? bus_ro.app_mem_rdata : bus.app_mem_rdata;

  pio_rw_mem_wide #(.WIDTH(W), .DEPTH_NBITS(DN), .WORD_NBITS(2), .REG_WR_EN(1'b1),
                    .INIT_EN(1'b1), .INIT_VAL(72'h5A)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .bus(bus.slave), .init_done(init_done));

  pio_rw_mem_wide #(.WIDTH(W), .DEPTH_NBITS(DN), .WORD_NBITS(2), .REG_WR_EN(1'b0),
                    .INIT_EN(1'b1), .INIT_VAL(72'h5A)) dut_ro (
    .clk(clk), .rst(rst), .clk_div(clk_div), .bus(bus_ro.slave), .init_done(init_done_ro));

  // clk_div: one cycle in three.
  initial begin
    int div_cnt;
    div_cnt = 0;
    forever begin
      @(negedge clk);
      div_cnt++;
      clk_div = (div_cnt % 3 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (entry/dword level) ----------------
  logic [W-1:0] m_mem [16];
  logic [31:0]  m_stage [2];
  logic [95:0]  m_snap;

  function automatic void m_pio_wr(input logic [31:0] addr, input logic [31:0] d);
    int w, e;
    w = int'(addr[3:2]);
    e = int'(addr[7:4]);
    if (w < 2) m_stage[w] = d;
    else if (w == 2) m_mem[e] = {d[7:0], m_stage[1], m_stage[0]};
  endfunction

  function automatic logic [31:0] m_pio_rd(input logic [31:0] addr);
    int w, e;
    w = int'(addr[3:2]);
    e = int'(addr[7:4]);
    if (w == 0) m_snap = {24'h0, m_mem[e]};
    if (w < 3) return m_snap[w*32 +: 32];
    return 32'h0;
  endfunction

  // ---------------- transaction tasks (called at negedge) ----------------
  task automatic pio_op(input bit is_wr, input logic [31:0] addr, input logic [31:0] din,
                        output logic [31:0] rdata);
    int n;
    t_addr = addr; t_din = din; t_ms = 1; t_wr = is_wr; t_rd = !is_wr;
    @(negedge clk);
    t_ms = 0; t_wr = 0; t_rd = 0;
    n = 0;
    while (o_mem_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("pio_ack_wait", 128'(n < 200), 128'(1));
    rdata = o_mem_rdata;
    n = 0;
    while (o_mem_ack === 1'b1 && n < 200) begin @(negedge clk); n++; end
    $display("pio %s addr=%h din=%h rdata=%h", is_wr ? "wr" : "rd", addr, din, rdata);
  endtask

  task automatic app_rd(input int e, output logic [W-1:0] data);
    t_app_rd = 1; t_app_raddr = DN'(e);
    @(negedge clk);
    t_app_rd = 0;
    check("app_ack", 128'(o_app_ack), 128'(1));
    data = o_app_rdata;
    $display("app rd entry=%0d data=%h", e, data);
  endtask

  task automatic app_wr(input int e, input logic [W-1:0] d);
    t_app_wr = 1; t_app_waddr = DN'(e); t_app_wdata = d;
    @(negedge clk);
    t_app_wr = 0;
    repeat (2) @(negedge clk);
    $display("app wr entry=%0d data=%h", e, d);
  endtask

  initial begin
    logic [31:0]  rd32, exp32;
    logic [W-1:0] rdw, wd;
    int n;

    for (int i = 0; i < 16; i++) m_mem[i] = 72'h5A;
    m_stage[0] = 0; m_stage[1] = 0; m_snap = 0;

    repeat (3) @(negedge clk);
    check("rst_mem_ack", 128'(bus.mem_ack), 128'(0));
    check("rst_mem_rdata", 128'(bus.mem_rdata), 128'(0));
    check("rst_app_ack", 128'(bus.app_mem_ack), 128'(0));
    check("rst_init_done", 128'(init_done), 128'(0));
    check("rst_init_done_ro", 128'(init_done_ro), 128'(0));
    rst = 0;
    n = 0;
    while (!init_done && n < 100) begin @(negedge clk); n++; end
    check("init_latency", 128'(n), 128'(17));
    check("init_done_ro", 128'(init_done_ro), 128'(1));

    for (int e = 0; e < 16; e++) begin
      app_rd(e, rdw);
      check("init_val", 128'(rdw), 128'(72'h5A));
    end

    // staged wide write
    pio_op(1, 32'h50, 32'h11111111, rd32); m_pio_wr(32'h50, 32'h11111111);
    pio_op(1, 32'h54, 32'h22222222, rd32); m_pio_wr(32'h54, 32'h22222222);
    app_rd(5, rdw);
    check("staged_no_write", 128'(rdw), 128'(72'h5A));
    pio_op(1, 32'h58, 32'h000000AB, rd32); m_pio_wr(32'h58, 32'h000000AB);
    app_rd(5, rdw);
    check("commit", 128'(rdw), 128'(72'hAB_22222222_11111111));

    // snapshot coherence
    pio_op(0, 32'h50, 0, rd32);
    check("snap_w0", 128'(rd32), 128'(32'h11111111)); void'(m_pio_rd(32'h50));
    app_wr(5, 72'h0); m_mem[5] = 72'h0;
    pio_op(0, 32'h54, 0, rd32);
    check("snap_w1", 128'(rd32), 128'(32'h22222222)); void'(m_pio_rd(32'h54));
    pio_op(0, 32'h58, 0, rd32);
    check("snap_w2", 128'(rd32), 128'(32'h000000AB)); void'(m_pio_rd(32'h58));

    // PIO read deferred behind a 3-cycle app read burst
    app_wr(5, 72'h33_44444444_55555555); m_mem[5] = 72'h33_44444444_55555555;
    t_addr = 32'h50; t_ms = 1; t_rd = 1;
    t_app_rd = 1; t_app_raddr = 4'd5;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      t_ms = 0; t_rd = 0;
      check("burst_app_ack", 128'(o_app_ack), 128'(1));
      check("burst_app_data", 128'(o_app_rdata), 128'(m_mem[int'(t_app_raddr)]));
      check("burst_pio_held", 128'(o_mem_ack), 128'(0));
      t_app_raddr = DN'(c + 1);
      if (c == 3) t_app_rd = 0;
    end
    n = 0;
    while (o_mem_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("burst_pio_ack_wait", 128'(n < 200), 128'(1));
    exp32 = m_pio_rd(32'h50);
    check("burst_pio_data", 128'(o_mem_rdata), 128'(exp32));
    n = 0;
    while (o_mem_ack === 1'b1 && n < 200) begin @(negedge clk); n++; end

    // PIO commit colliding with an app write to the same entry
    pio_op(1, 32'h20, 32'hAAAA0000, rd32); m_pio_wr(32'h20, 32'hAAAA0000);
    pio_op(1, 32'h24, 32'hBBBB1111, rd32); m_pio_wr(32'h24, 32'hBBBB1111);
    t_app_wr = 1; t_app_waddr = 4'd2; t_app_wdata = 72'hFF_FFFFFFFF_FFFFFFFF;
    t_addr = 32'h28; t_din = 32'h000000CC; t_ms = 1; t_wr = 1;
    @(negedge clk);
    t_app_wr = 0; t_ms = 0; t_wr = 0;
    m_mem[2] = 72'hFF_FFFFFFFF_FFFFFFFF; m_pio_wr(32'h28, 32'h000000CC);
    n = 0;
    while (o_mem_ack !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("collide_ack_wait", 128'(n < 200), 128'(1));
    n = 0;
    while (o_mem_ack === 1'b1 && n < 200) begin @(negedge clk); n++; end
    app_rd(2, rdw);
    check("collide_pio_wins", 128'(rdw), 128'(72'hCC_BBBB1111_AAAA0000));

    // out-of-range dword
    pio_op(0, 32'h5C, 0, rd32);
    check("w3_read_zero", 128'(rd32), 128'(0));
    pio_op(1, 32'h5C, 32'hDEADBEEF, rd32);
    app_rd(5, rdw);
    check("w3_write_ignored", 128'(rdw), 128'(m_mem[5]));

    // REG_WR_EN=0 instance
    use_ro = 1;
    pio_op(1, 32'h50, 32'h12345678, rd32);
    pio_op(1, 32'h54, 32'h9ABCDEF0, rd32);
    pio_op(1, 32'h58, 32'h000000EE, rd32);
    app_rd(5, rdw);
    check("ro_unchanged", 128'(rdw), 128'(72'h5A));
    pio_op(0, 32'h50, 0, rd32);
    check("ro_read", 128'(rd32), 128'(32'h5A));
    use_ro = 0;

    // randomized mix against the model
    for (int k = 0; k < 80; k++) begin
      int op, e, w;
      logic [31:0] a, d;
      op = int'($urandom_range(0, 3));
      e  = int'($urandom_range(0, 15));
      w  = int'($urandom_range(0, 3));
      a  = {24'h0, 4'(e), 2'(w), 2'b00};
      d  = $urandom;
      case (op)
        0: begin pio_op(1, a, d, rd32); m_pio_wr(a, d); end
        1: begin
          pio_op(0, a, 0, rd32);
          exp32 = m_pio_rd(a);
          check("rand_pio_rd", 128'(rd32), 128'(exp32));
        end
        2: begin
          app_rd(e, rdw);
          check("rand_app_rd", 128'(rdw), 128'(m_mem[e]));
        end
        default: begin
          wd = {8'($urandom), $urandom, $urandom};
          app_wr(e, wd); m_mem[e] = wd;
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
